// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the two-car game screen controller: screen encodings,
// pixel width and default timing parameters.
package screen_sequencer_pkg;

    localparam int unsigned RGB_W                = 12;
    localparam int unsigned DEF_FRAMES_PER_DIGIT = 60;
    localparam int unsigned DEF_COUNT_DIGITS     = 3;
    localparam int unsigned DEF_OVER_FRAMES      = 300;

    typedef enum logic [2:0] {
        SCR_START     = 3'd0,
        SCR_COUNTDOWN = 3'd1,
        SCR_PLAY      = 3'd2,
        SCR_PAUSE     = 3'd3,
        SCR_OVER      = 3'd4
    } screen_t;

    // Halve each 4-bit channel of a {R,G,B} pixel.
    function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] rgb);
        return {1'b0, rgb[11:9], 1'b0, rgb[7:5], 1'b0, rgb[3:1]};
    endfunction

endpackage

// File: rtl/screen_sequencer_frame_button.sv
// Gamepad button conditioner: 2-flop synchronizer, then a level sample taken once
// per frame; press is the rising edge between consecutive frame samples.
module screen_sequencer_frame_button (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sample <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (frame_tick) begin
                sample <= sync2;
            end
        end
    end

    // Sampling only at frame rate is what debounces the button.
    assign press = frame_tick & sync2 & ~sample;

endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer: frame-synchronous START/COUNTDOWN/PLAY/PAUSE/OVER controller
// plus the registered pixel mux that drives the VGA outputs.
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter int unsigned FRAMES_PER_DIGIT = DEF_FRAMES_PER_DIGIT,
    parameter int unsigned COUNT_DIGITS     = DEF_COUNT_DIGITS,
    parameter int unsigned OVER_FRAMES      = DEF_OVER_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             active,
    input  logic             btn_start,
    input  logic             btn_pause,
    input  logic             crash,
    input  logic [RGB_W-1:0] start_rgb,
    input  logic [RGB_W-1:0] game_rgb,
    input  logic [RGB_W-1:0] over_rgb,
    output logic [3:0]       VGA_R,
    output logic [3:0]       VGA_G,
    output logic [3:0]       VGA_B,
    output logic [2:0]       screen,
    output logic             game_run,
    output logic             game_reset,
    output logic [1:0]       digit
);

    localparam int unsigned MAX_FRAMES = (FRAMES_PER_DIGIT > OVER_FRAMES) ?
                                         FRAMES_PER_DIGIT : OVER_FRAMES;
    localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    screen_t          state;
    logic [CNT_W-1:0] frame_cnt;
    logic             crash_seen;
    logic             start_press;
    logic             pause_press;
    logic [RGB_W-1:0] rgb_q;

    screen_sequencer_frame_button u_start_btn (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn        (btn_start),
        .press      (start_press)
    );

    screen_sequencer_frame_button u_pause_btn (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn        (btn_pause),
        .press      (pause_press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCR_START;
            frame_cnt  <= '0;
            crash_seen <= 1'b0;
            game_run   <= 1'b0;
            game_reset <= 1'b0;
            digit      <= 2'd0;
        end else begin
            game_reset <= 1'b0;
            if (state == SCR_PLAY && crash) begin
                crash_seen <= 1'b1;
            end
            if (frame_tick) begin
                case (state)
                    SCR_START: begin
                        if (start_press) begin
                            state      <= SCR_COUNTDOWN;
                            digit      <= 2'(COUNT_DIGITS);
                            frame_cnt  <= CNT_W'(FRAMES_PER_DIGIT - 1);
                            game_reset <= 1'b1;
                        end
                    end
                    SCR_COUNTDOWN: begin
                        if (frame_cnt != '0) begin
                            frame_cnt <= frame_cnt - 1'b1;
                        end else if (digit > 2'd1) begin
                            digit     <= digit - 2'd1;
                            frame_cnt <= CNT_W'(FRAMES_PER_DIGIT - 1);
                        end else begin
                            state    <= SCR_PLAY;
                            digit    <= 2'd0;
                            game_run <= 1'b1;
                        end
                    end
                    SCR_PLAY: begin
                        // A crash on the tick cycle itself still wins over pause.
                        if (crash_seen || crash) begin
                            state      <= SCR_OVER;
                            frame_cnt  <= CNT_W'(OVER_FRAMES - 1);
                            game_run   <= 1'b0;
                            crash_seen <= 1'b0;
                        end else if (pause_press) begin
                            state      <= SCR_PAUSE;
                            game_run   <= 1'b0;
                            crash_seen <= 1'b0;
                        end
                    end
                    SCR_PAUSE: begin
                        if (start_press) begin
                            state      <= SCR_START;
                            game_reset <= 1'b1;
                        end else if (pause_press) begin
                            state    <= SCR_PLAY;
                            game_run <= 1'b1;
                        end
                    end
                    SCR_OVER: begin
                        if (frame_cnt == '0 || start_press) begin
                            state     <= SCR_START;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state    <= SCR_START;
                        game_run <= 1'b0;
                        digit    <= 2'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !active) begin
            rgb_q <= '0;
        end else begin
            case (state)
                SCR_START:              rgb_q <= start_rgb;
                SCR_COUNTDOWN, SCR_PLAY: rgb_q <= game_rgb;
                SCR_PAUSE:              rgb_q <= dim_rgb(game_rgb);
                SCR_OVER:               rgb_q <= over_rgb;
                default:                rgb_q <= '0;
            endcase
        end
    end

    assign screen = state;
    assign VGA_R  = rgb_q[11:8];
    assign VGA_G  = rgb_q[7:4];
    assign VGA_B  = rgb_q[3:0];

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: directed scenarios then random frames,
// compared against a tick-counting reference model of the screen rules.
module tb_screen_sequencer;

    localparam int F = 2;
    localparam int C = 3;
    localparam int O = 4;
    localparam int FRAME_CYCLES = 6;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        active;
    logic        btn_start;
    logic        btn_pause;
    logic        crash;
    logic [11:0] start_rgb;
    logic [11:0] game_rgb;
    logic [11:0] over_rgb;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic [2:0]  screen;
    logic        game_run;
    logic        game_reset;
    logic [1:0]  digit;

    int checks;
    int failures;

    // Reference model: screen number, ticks since entering current screen.
    int m_screen;
    int m_ticks;
    bit m_crash;
    bit m_prev_s;
    bit m_prev_p;
    bit m_pulse;

    screen_sequencer #(
        .FRAMES_PER_DIGIT (F),
        .COUNT_DIGITS     (C),
        .OVER_FRAMES      (O)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .active     (active),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .crash      (crash),
        .start_rgb  (start_rgb),
        .game_rgb   (game_rgb),
        .over_rgb   (over_rgb),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .screen     (screen),
        .game_run   (game_run),
        .game_reset (game_reset),
        .digit      (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_px(input bit a, input int scr,
                                            input logic [11:0] s, input logic [11:0] g,
                                            input logic [11:0] o);
        logic [3:0] r, gg, b;
        if (!a) return 12'h000;
        case (scr)
            0:       return s;
            1, 2:    return g;
            3: begin
                r  = g[11:8] / 2;
                gg = g[7:4] / 2;
                b  = g[3:0] / 2;
                return {r, gg, b};
            end
            4:       return o;
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        m_screen = 0;
        m_ticks  = 0;
        m_crash  = 0;
        m_prev_s = 0;
        m_prev_p = 0;
        m_pulse  = 0;
    endtask

    task automatic model_tick(input bit s, input bit p);
        bit sp, pp;
        sp = s && !m_prev_s;
        pp = p && !m_prev_p;
        m_prev_s = s;
        m_prev_p = p;
        m_pulse  = 0;
        case (m_screen)
            0: if (sp) begin m_screen = 1; m_ticks = 0; m_pulse = 1; end
            1: begin
                m_ticks++;
                if (m_ticks == C * F) m_screen = 2;
            end
            2: begin
                if (m_crash) begin m_screen = 4; m_ticks = 0; m_crash = 0; end
                else if (pp) begin m_screen = 3; m_crash = 0; end
            end
            3: begin
                if (sp) begin m_screen = 0; m_pulse = 1; end
                else if (pp) m_screen = 2;
            end
            4: begin
                m_ticks++;
                if (m_ticks == O || sp) m_screen = 0;
            end
            default: m_screen = 0;
        endcase
    endtask

    // One clock cycle; lvl_s/lvl_p are the settled button levels seen at a tick.
    task automatic cycle(input bit tick, input bit c, input bit a, input logic [11:0] s,
                         input logic [11:0] g, input logic [11:0] o,
                         input bit lvl_s, input bit lvl_p);
        logic [11:0] px;
        frame_tick = tick;
        crash      = c;
        active     = a;
        start_rgb  = s;
        game_rgb   = g;
        over_rgb   = o;
        px = exp_px(a, m_screen, s, g, o);
        if (c && m_screen == 2) m_crash = 1;
        if (tick) model_tick(lvl_s, lvl_p);
        @(posedge clk);
        #1;
        chk("pixel", {20'd0, VGA_R, VGA_G, VGA_B}, {20'd0, px});
        if (tick) begin
            chk("screen", {29'd0, screen}, m_screen);
            chk("digit", {30'd0, digit}, (m_screen == 1) ? (C - m_ticks / F) : 0);
            chk("game_run", {31'd0, game_run}, (m_screen == 2) ? 1 : 0);
            chk("game_reset_tick", {31'd0, game_reset}, {31'd0, m_pulse});
        end else begin
            chk("game_reset_idle", {31'd0, game_reset}, 0);
        end
        frame_tick = 1'b0;
        crash      = 1'b0;
    endtask

    task automatic frame(input bit s, input bit p, input int crash_at, input bit glitch);
        for (int c = 0; c < FRAME_CYCLES; c++) begin
            btn_start = (glitch && c == 1) ? !s : s;
            btn_pause = p;
            cycle(c == FRAME_CYCLES - 1, c == crash_at, ($urandom % 4) != 0,
                  12'($urandom), 12'($urandom), 12'($urandom), s, p);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        frame_tick = 1'b0;
        crash      = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_screen", {29'd0, screen}, 0);
        chk("rst_game_reset", {31'd0, game_reset}, 0);
        chk("rst_game_run", {31'd0, game_run}, 0);
        chk("rst_digit", {30'd0, digit}, 0);
        chk("rst_vga", {20'd0, VGA_R, VGA_G, VGA_B}, 0);
        reset = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        frame_tick = 1'b0;
        active     = 1'b1;
        btn_start  = 1'b0;
        btn_pause  = 1'b0;
        crash      = 1'b0;
        start_rgb  = 12'h237;
        game_rgb   = 12'h000;
        over_rgb   = 12'h000;
        model_reset();
        @(posedge clk);
        do_reset();

        // Idle start screen passes start_rgb through one cycle later.
        cycle(0, 0, 1, 12'h237, 12'h000, 12'h000, 0, 0);
        chk("idle_vga", {20'd0, VGA_R, VGA_G, VGA_B}, 32'h237);
        frame(0, 0, -1, 0);

        // Start held across 5 ticks with glitches: one entry, one game_reset.
        repeat (5) frame(1, 0, -1, 1);
        // Remaining countdown with pause presses that must be ignored.
        frame(1, 1, -1, 0);
        frame(1, 0, -1, 0);
        chk("in_play", {29'd0, screen}, 2);

        // Crash mid-frame beats a pause press on the next tick.
        frame(0, 1, 2, 0);
        chk("crash_over", {29'd0, screen}, 4);

        // Over times out after O ticks.
        repeat (O) frame(0, 0, -1, 0);
        chk("over_timeout", {29'd0, screen}, 0);

        // Countdown into play, then pause.
        frame(1, 0, -1, 0);
        repeat (C * F) frame(0, 0, -1, 0);
        frame(0, 1, -1, 0);
        chk("paused", {29'd0, screen}, 3);
        cycle(0, 0, 1, 12'h000, 12'hFFF, 12'h000, 0, 1);
        chk("dim_vga", {20'd0, VGA_R, VGA_G, VGA_B}, 32'h777);
        frame(0, 0, -1, 0);
        // Start and pause on the same tick: abort to START with game_reset.
        frame(1, 1, -1, 0);
        chk("pause_abort", {29'd0, screen}, 0);
        frame(0, 0, -1, 0);

        // Play, crash on the tick cycle, then start press on over tick 2.
        frame(1, 0, -1, 0);
        repeat (C * F) frame(0, 0, -1, 0);
        frame(0, 0, FRAME_CYCLES - 1, 0);
        chk("tick_crash", {29'd0, screen}, 4);
        frame(0, 0, -1, 0);
        frame(1, 0, -1, 0);
        chk("over_start", {29'd0, screen}, 0);
        frame(1, 0, -1, 0);

        // Reset mid-countdown.
        frame(0, 0, -1, 0);
        frame(1, 0, -1, 0);
        do_reset();

        // Random frames.
        for (int i = 0; i < 150; i++) begin
            if (($urandom % 50) == 0) begin
                do_reset();
            end else begin
                frame(($urandom % 3) == 0, ($urandom % 3) == 0,
                      (($urandom % 4) == 0) ? int'($urandom % FRAME_CYCLES) : -1,
                      ($urandom % 2) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
